// File: rtl/dvp_gen_pkg.sv
// dvp_gen_pkg: shared types, colours and helpers for the DVP frame generator.
// States, pattern codes, RGB565 constants, gray/bar colour conversion.
package dvp_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        ACTIVE,
        VFP
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_GRAY,
        PAT_BOX,
        PAT_CHECKER
    } pattern_t;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;
    localparam int POS_W  = 12;

    localparam logic [15:0] C_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_CYAN    = 16'h07FF;
    localparam logic [15:0] C_GREEN   = 16'h07E0;
    localparam logic [15:0] C_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RED     = 16'hF800;
    localparam logic [15:0] C_BLUE    = 16'h001F;
    localparam logic [15:0] C_BLACK   = 16'h0000;

    function automatic logic [15:0] gray2rgb565(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        unique case (idx)
            3'd0: c = C_WHITE;
            3'd1: c = C_YELLOW;
            3'd2: c = C_CYAN;
            3'd3: c = C_GREEN;
            3'd4: c = C_MAGENTA;
            3'd5: c = C_RED;
            3'd6: c = C_BLUE;
            default: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_frame_gen_pix.sv
// dvp_pattern_pix: registered pixel generator for the DVP frame generator.
// Output is zero whenever the pixel is outside the active window.
module dvp_pattern_pix
    import dvp_gen_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int BOX_SIZE  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    active,
    input  logic [HCNT_W-1:0]       x,
    input  logic [VCNT_W-1:0]       y,
    input  pattern_t                pattern,
    input  logic [7:0]              gray,
    input  logic signed [POS_W-1:0] bx,
    input  logic signed [POS_W-1:0] by,
    output logic [15:0]             pix
);

    localparam int BAR_W = ((IMG_HDISP >> 3) > 0) ? (IMG_HDISP >> 3) : 1;
    localparam logic signed [POS_W:0] BOX_S = (POS_W+1)'(BOX_SIZE);

    logic [2:0]              bar_idx;
    logic signed [POS_W:0]   xs;
    logic signed [POS_W:0]   ys;
    logic signed [POS_W:0]   bxs;
    logic signed [POS_W:0]   bys;
    logic                    in_box;
    logic [15:0]             pix_d;

    assign xs  = $signed({2'b00, x});
    assign ys  = $signed({3'b000, y});
    assign bxs = {bx[POS_W-1], bx};
    assign bys = {by[POS_W-1], by};

    assign in_box = (xs >= bxs) && (xs < bxs + BOX_S) &&
                    (ys >= bys) && (ys < bys + BOX_S);

    // Bar index saturates at 7 for any trailing columns
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (int'(x) >= k * BAR_W) begin
                bar_idx = 3'(k);
            end
        end
    end

    // Pattern select for the current pixel
    always_comb begin
        pix_d = C_BLACK;
        if (active) begin
            unique case (pattern)
                PAT_BARS:    pix_d = bar_color(bar_idx);
                PAT_GRAY:    pix_d = gray2rgb565(gray);
                PAT_BOX:     pix_d = in_box ? C_WHITE : C_BLACK;
                PAT_CHECKER: pix_d = (x[5] ^ y[5]) ? C_WHITE : C_BLACK;
                default:     pix_d = C_BLACK;
            endcase
        end
    end

    // Pixel register, held while the pixel clock enable is low
    always_ff @(posedge clk) begin
        if (rst) begin
            pix <= '0;
        end else if (ce) begin
            pix <= pix_d;
        end
    end

endmodule

// File: rtl/dvp_frame_gen.sv
// dvp_frame_gen: synthetic RGB565 DVP source with a moving-box test pattern.
// Define DVP_GEN_NOISE_EN to add LFSR noise into the colour LSBs.
module dvp_frame_gen
    import dvp_gen_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 160,
    parameter int VS_LINES  = 2,
    parameter int V_BP      = 8,
    parameter int V_FP      = 10,
    parameter int BOX_SIZE  = 64,
    parameter int BOX_STEP  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pix_ce,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  gray_level,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic        dvp_valid,
    output logic [15:0] dvp_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = IMG_HDISP + H_BLANK;

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(IMG_HDISP);

    localparam logic [VCNT_W-1:0] N_VS  = VCNT_W'(VS_LINES);
    localparam logic [VCNT_W-1:0] N_BP  = VCNT_W'(V_BP);
    localparam logic [VCNT_W-1:0] N_ACT = VCNT_W'(IMG_VDISP);
    localparam logic [VCNT_W-1:0] N_FP  = VCNT_W'(V_FP);

    localparam logic signed [POS_W-1:0] X_LIM = POS_W'(IMG_HDISP - BOX_SIZE);
    localparam logic signed [POS_W-1:0] Y_LIM = POS_W'(IMG_VDISP - BOX_SIZE);
    localparam logic signed [POS_W-1:0] STEP  = POS_W'(BOX_STEP);

    state_t                  state_q;
    state_t                  state_d;
    logic [HCNT_W-1:0]       hcnt_q;
    logic [VCNT_W-1:0]       vcnt_q;
    logic [VCNT_W-1:0]       region_lines;
    logic                    line_end;
    logic                    region_end;
    logic                    frame_end;
    logic                    active_px;
    pattern_t                pat_q;
    logic [7:0]              gray_q;
    logic signed [POS_W-1:0] bx_q;
    logic signed [POS_W-1:0] by_q;
    logic                    dx_q;
    logic                    dy_q;
    logic [POS_W:0]          x_upd;
    logic [POS_W:0]          y_upd;
    logic [15:0]             pix_q;
    logic [15:0]             noise;

    // One axis of box motion; dir=1 moves toward zero. Returns {dir, pos}.
    function automatic logic [POS_W:0] box_move(
        input logic signed [POS_W-1:0] pos,
        input logic                    dir,
        input logic signed [POS_W-1:0] lim
    );
        logic signed [POS_W-1:0] nxt;
        nxt = dir ? (pos - STEP) : (pos + STEP);
        if (nxt > lim) begin
            return {1'b1, lim};
        end else if (nxt < 0) begin
            return {1'b0, {POS_W{1'b0}}};
        end
        return {dir, nxt};
    endfunction

    assign line_end   = (hcnt_q == H_LAST);
    assign region_end = (state_q != IDLE) && line_end &&
                        (vcnt_q == region_lines - 1'b1);
    assign frame_end  = (state_q == VFP) && region_end;
    assign active_px  = (state_q == ACTIVE) && (hcnt_q < H_ACT);
    assign x_upd      = box_move(bx_q, dx_q, X_LIM);
    assign y_upd      = box_move(by_q, dy_q, Y_LIM);

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Region length and next-state logic; enable only matters at frame edges
    always_comb begin
        state_d      = state_q;
        region_lines = 10'd1;
        unique case (state_q)
            VSYNC:   region_lines = N_VS;
            VBP:     region_lines = N_BP;
            ACTIVE:  region_lines = N_ACT;
            VFP:     region_lines = N_FP;
            default: region_lines = 10'd1;
        endcase
        if (pix_ce) begin
            unique case (state_q)
                IDLE:    if (enable)     state_d = VSYNC;
                VSYNC:   if (region_end) state_d = VBP;
                VBP:     if (region_end) state_d = ACTIVE;
                ACTIVE:  if (region_end) state_d = VFP;
                VFP:     if (region_end) state_d = enable ? VSYNC : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Pixel and line counters; line count restarts in every region
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else if (pix_ce) begin
            if (state_q == IDLE) begin
                hcnt_q <= '0;
                vcnt_q <= '0;
            end else if (line_end) begin
                hcnt_q <= '0;
                vcnt_q <= region_end ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
            end
        end
    end

    // Pattern controls captured on entry to vsync for the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PAT_BARS;
            gray_q <= '0;
        end else if (state_d == VSYNC && state_q != VSYNC) begin
            pat_q  <= pattern_t'(pattern_sel);
            gray_q <= gray_level;
        end
    end

    // Box position steps once per frame, bouncing off the edges
    always_ff @(posedge clk) begin
        if (rst) begin
            bx_q <= '0;
            by_q <= '0;
            dx_q <= 1'b0;
            dy_q <= 1'b0;
        end else if (pix_ce && frame_end) begin
            dx_q <= x_upd[POS_W];
            bx_q <= x_upd[POS_W-1:0];
            dy_q <= y_upd[POS_W];
            by_q <= y_upd[POS_W-1:0];
        end
    end

    // Registered sync/strobe outputs and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else if (pix_ce) begin
            dvp_vsync  <= (state_q == VSYNC);
            dvp_href   <= active_px;
            dvp_valid  <= active_px;
            frame_done <= frame_end;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end else begin
            dvp_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    dvp_pattern_pix #(
        .IMG_HDISP (IMG_HDISP),
        .BOX_SIZE  (BOX_SIZE)
    ) u_pix (
        .clk     (clk),
        .rst     (rst),
        .ce      (pix_ce),
        .active  (active_px),
        .x       (hcnt_q),
        .y       (vcnt_q),
        .pattern (pat_q),
        .gray    (gray_q),
        .bx      (bx_q),
        .by      (by_q),
        .pix     (pix_q)
    );

`ifdef DVP_GEN_NOISE_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Noise LFSR steps on each edge that launches a valid pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else if (pix_ce && active_px) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end

    assign noise = dvp_href ?
                   {3'b000, lfsr_q[1:0], 4'b0000, lfsr_q[1:0], 3'b000, lfsr_q[1:0]} :
                   16'h0000;
`else
    assign noise = 16'h0000;
`endif

    assign dvp_data = pix_q ^ noise;

endmodule

// File: tb/tb_dvp_frame_gen.sv
// tb_dvp_frame_gen: directed bench for the DVP frame generator.
// Small geometry: 16x4 active, 20-cycle lines, 1/1/1 blank lines.
module tb_dvp_frame_gen;

    localparam int HD   = 16;
    localparam int VD   = 4;
    localparam int HB   = 4;
    localparam int VS   = 1;
    localparam int BP   = 1;
    localparam int FP   = 1;
    localparam int BOX  = 4;
    localparam int STEP = 8;

    localparam logic [15:0] BARS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };
    localparam int BX_SEQ [5] = '{0, 8, 12, 4, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pix_ce = 1'b1;
    logic [1:0]  pattern_sel = 2'd0;
    logic [7:0]  gray_level = 8'd0;
    logic        dvp_vsync;
    logic        dvp_href;
    logic        dvp_valid;
    logic [15:0] dvp_data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit ce_toggle = 1'b0;
    int cur_sel = 0;
    int cur_bx  = 0;
    int exp_fcnt = 0;

    int vs_cycles, valids, lines, bad_lines, pix_err, nz_out;
    int hold_err, fd_pulses, fw, mx, my, lv;
    logic [15:0] first_pix, p14, p15, pd;
    logic ph = 1'b0;
    logic pv = 1'b0;

    dvp_frame_gen #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .H_BLANK   (HB),
        .VS_LINES  (VS),
        .V_BP      (BP),
        .V_FP      (FP),
        .BOX_SIZE  (BOX),
        .BOX_STEP  (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pix_ce      (pix_ce),
        .pattern_sel (pattern_sel),
        .gray_level  (gray_level),
        .dvp_vsync   (dvp_vsync),
        .dvp_href    (dvp_href),
        .dvp_valid   (dvp_valid),
        .dvp_data    (dvp_data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        pix_ce = ce_toggle ? ~pix_ce : 1'b1;
    end

    function automatic logic [15:0] exp_pix(input int px, input int py);
        int bi;
        case (cur_sel)
            0: begin
                bi = px / 2;
                if (bi > 7) bi = 7;
                return BARS[bi];
            end
            1: return 16'h8410;
            2: return (px >= cur_bx && px < cur_bx + BOX) ? 16'hFFFF : 16'h0000;
            default: return ((((px >> 5) ^ (py >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_stats();
        vs_cycles = 0; valids = 0; lines = 0; bad_lines = 0;
        pix_err = 0; nz_out = 0; hold_err = 0; fd_pulses = 0;
        fw = -1; lv = 0; mx = 0; my = 0;
        first_pix = 16'h0; p14 = 16'h1234; p15 = 16'h1234;
    endtask

    task automatic wait_fd(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_href(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (dvp_href) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input string tag);
        bit ok;
        clear_stats();
        enable = 1'b1;
        cyc(4);
        enable = 1'b0;
        wait_fd(2000, ok);
        chk({tag, "_fd_seen"}, 32'(ok), 1);
        exp_fcnt++;
        cyc(3);
    endtask

    // Frame monitor: counts syncs/strobes and checks pixels against the model
    always @(negedge clk) begin
        if (dvp_vsync) begin
            vs_cycles++;
            mx = 0;
            my = 0;
        end
        if (dvp_valid) begin
            valids++;
            lv++;
            if (dvp_data !== exp_pix(mx, my)) pix_err++;
            if (valids == 1) first_pix = dvp_data;
            if (my == 0 && mx == 14) p14 = dvp_data;
            if (my == 0 && mx == 15) p15 = dvp_data;
            if (my == 0 && dvp_data == 16'hFFFF && fw < 0) fw = mx;
            mx++;
        end
        if (!dvp_href && dvp_data != 16'h0) nz_out++;
        if (ce_toggle && pv && !dvp_valid && (!dvp_href || dvp_data !== pd)) hold_err++;
        if (ph && !dvp_href) begin
            lines++;
            if (lv != HD) bad_lines++;
            lv = 0;
            my++;
            mx = 0;
        end
        if (frame_done) fd_pulses++;
        ph = dvp_href;
        pv = dvp_valid;
        pd = dvp_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        clear_stats();
        rst = 1'b1;
        cyc(3);
        chk("reset_outs", {dvp_vsync, dvp_href, dvp_valid, dvp_data, frame_done}, 0);
        chk("reset_fcnt", frame_cnt, 0);
        rst = 1'b0;
        cyc(2);

        // colour bars
        cur_sel = 0;
        pattern_sel = 2'd0;
        run_frame("t1");
        chk("t1_vsync", vs_cycles, 20);
        chk("t1_lines", lines, VD);
        chk("t1_valids", valids, HD * VD);
        chk("t1_badlines", bad_lines, 0);
        chk("t1_pixerr", pix_err, 0);
        chk("t1_first", first_pix, 16'hFFFF);
        chk("t1_p14", p14, 16'h0000);
        chk("t1_p15", p15, 16'h0000);
        chk("t1_fcnt", frame_cnt, exp_fcnt);

        // flat gray
        cur_sel = 1;
        pattern_sel = 2'd1;
        gray_level = 8'h80;
        run_frame("t2");
        chk("t2_pixerr", pix_err, 0);
        chk("t2_outside", nz_out, 0);
        chk("t2_first", first_pix, 16'h8410);
        chk("t2_valids", valids, HD * VD);

        // pix_ce toggling
        cur_sel = 0;
        pattern_sel = 2'd0;
        ce_toggle = 1'b1;
        run_frame("t4");
        ce_toggle = 1'b0;
        cyc(2);
        chk("t4_vsync", vs_cycles, 40);
        chk("t4_valids", valids, HD * VD);
        chk("t4_lines", lines, VD);
        chk("t4_badlines", bad_lines, 0);
        chk("t4_pixerr", pix_err, 0);
        chk("t4_hold", hold_err, 0);

        // enable dropped mid-active
        clear_stats();
        enable = 1'b1;
        wait_href(1000, ok);
        chk("t5_href_seen", 32'(ok), 1);
        enable = 1'b0;
        wait_fd(2000, ok);
        chk("t5_fd_seen", 32'(ok), 1);
        exp_fcnt++;
        chk("t5_fcnt", frame_cnt, exp_fcnt);
        cyc(200);
        chk("t5_fd_pulses", fd_pulses, 1);
        chk("t5_vsync", vs_cycles, 20);
        chk("t5_idle_outs", {dvp_vsync, dvp_href, dvp_valid, dvp_data, frame_done}, 0);
        chk("t5_fcnt_hold", frame_cnt, exp_fcnt);

        // reset mid-line, then a full frame from vsync
        enable = 1'b1;
        wait_href(1000, ok);
        chk("t6_href_seen", 32'(ok), 1);
        cyc(3);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_outs", {dvp_vsync, dvp_href, dvp_valid, dvp_data, frame_done}, 0);
        chk("t6_rst_fcnt", frame_cnt, 0);
        exp_fcnt = 0;
        rst = 1'b0;
        cyc(1);
        clear_stats();
        cyc(4);
        enable = 1'b0;
        wait_fd(2000, ok);
        chk("t6_fd_seen", 32'(ok), 1);
        exp_fcnt++;
        cyc(3);
        chk("t6_vsync", vs_cycles, 20);
        chk("t6_lines", lines, VD);
        chk("t6_valids", valids, HD * VD);
        chk("t6_pixerr", pix_err, 0);
        chk("t6_fcnt", frame_cnt, exp_fcnt);

        // moving box: bounce sequence from a fresh reset
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        exp_fcnt = 0;
        cur_sel = 2;
        pattern_sel = 2'd2;
        for (int f = 0; f < 5; f++) begin
            cur_bx = BX_SEQ[f];
            run_frame($sformatf("t3_f%0d", f));
            chk($sformatf("t3_pixerr_f%0d", f), pix_err, 0);
            chk($sformatf("t3_bx_f%0d", f), 32'(fw), 32'(BX_SEQ[f]));
        end
        chk("t3_fcnt", frame_cnt, exp_fcnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
